// File: rtl/pzvip_tilelink_channel_fifo.sv
`timescale 1ns/1ps
// Valid/ready channel FIFO with a registered head entry and LFSR-driven upstream
// throttling. It also records sticky flags when the upstream breaks the hold rules.
module pzvip_tilelink_channel_fifo #(
   parameter int          WIDTH     = 64,
   parameter int          DEPTH     = 4,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [WIDTH-1:0]           s_payload,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [WIDTH-1:0]           m_payload,
   input  logic [1:0]                 throttle_mode,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [1:0]                 violation,
   input  logic                       clear_violation
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_head;
   logic [15:0]      r_lfsr;
   logic [1:0]       r_violation;
   logic             r_pend;
   logic [WIDTH-1:0] r_prev_payload;

   logic             w_gate;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic [AW-1:0]    w_next_rptr;
   logic [1:0]       w_new_viol;
   logic [1:0]       w_viol_next;

   // Upstream throttle gate selected by mode from the free-running LFSR.
   always_comb begin
      w_gate = 1'b0;
      case (throttle_mode)
         2'b00:   w_gate = 1'b1;
         2'b01:   w_gate = r_lfsr[0];
         2'b10:   w_gate = 1'b0;
         2'b11:   w_gate = (r_lfsr[1:0] != 2'b00);
         default: w_gate = 1'b0;
      endcase
   end

   // reset_n is folded in so that s_ready drops the moment reset asserts.
   assign w_full      = (r_count == CW'(DEPTH));
   assign s_ready     = reset_n && !w_full && w_gate;
   assign m_valid     = (r_count != {CW{1'b0}});
   assign m_payload   = r_head;
   assign count       = r_count;
   assign violation   = r_violation;
   assign w_push      = s_valid && s_ready;
   assign w_pop       = m_valid && m_ready;
   assign w_next_rptr = r_rptr + AW'(1);

   // A hold violation is judged against what was offered while stalled last cycle.
   always_comb begin
      w_new_viol[0] = r_pend && !s_valid;
      w_new_viol[1] = r_pend && s_valid && (s_payload != r_prev_payload);
      if (clear_violation) begin
         w_viol_next = w_new_viol;
      end else begin
         w_viol_next = r_violation | w_new_viol;
      end
   end

   // Storage array; written on push, never reset.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wptr] <= s_payload;
      end
   end

   // Pointers, occupancy and the registered head entry.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr  <= {AW{1'b0}};
         r_rptr  <= {AW{1'b0}};
         r_count <= {CW{1'b0}};
         r_head  <= {WIDTH{1'b0}};
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= w_next_rptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         // The incoming word becomes head when the FIFO is, or is about to be, empty.
         if (w_push && ((r_count == {CW{1'b0}}) || ((r_count == CW'(1)) && w_pop))) begin
            r_head <= s_payload;
         end else if (w_pop && (r_count > CW'(1))) begin
            r_head <= r_mem[w_next_rptr];
         end
      end
   end

   // Fibonacci LFSR (taps 16,14,13,11) and hold-rule tracking.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_lfsr         <= LFSR_SEED;
         r_violation    <= 2'b00;
         r_pend         <= 1'b0;
         r_prev_payload <= {WIDTH{1'b0}};
      end else begin
         r_lfsr         <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
         r_violation    <= w_viol_next;
         r_pend         <= s_valid && !s_ready;
         r_prev_payload <= s_payload;
      end
   end

endmodule

// File: tb/tb_pzvip_tilelink_channel_fifo.sv
`timescale 1ns/1ps
// Self-checking bench: directed table, hand sequences for the corner cases, and
// random traffic against a queue-based reference model.
module tb_pzvip_tilelink_channel_fifo;

   localparam int WIDTH = 64;
   localparam int DEPTH = 4;

   logic             clock = 1'b0;
   logic             reset_n;
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_payload;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_payload;
   logic [1:0]       throttle_mode;
   logic [2:0]       count;
   logic [1:0]       violation;
   logic             clear_violation;

   int checks   = 0;
   int failures = 0;

   logic [WIDTH-1:0] mq[$];
   logic [15:0]      m_lfsr;
   logic [1:0]       m_viol;
   bit               m_pend;
   logic [WIDTH-1:0] m_prev;

   typedef struct {
      bit          sv;
      logic [63:0] pl;
      bit          mr;
      logic [2:0]  e_cnt;
      bit          e_mv;
      logic [63:0] e_mp;
      bit          e_sr;
   } vec_t;
   vec_t tbl[10];

   always #5 clock = ~clock;

   pzvip_tilelink_channel_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LFSR_SEED(16'hACE1)) dut (
      .clock(clock), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
      .s_payload(s_payload), .m_valid(m_valid), .m_ready(m_ready), .m_payload(m_payload),
      .throttle_mode(throttle_mode), .count(count), .violation(violation),
      .clear_violation(clear_violation)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit gate_of(input logic [1:0] md, input logic [15:0] l);
      case (md)
         2'b00:   return 1'b1;
         2'b01:   return l[0];
         2'b10:   return 1'b0;
         default: return (l % 4) != 0;
      endcase
   endfunction

   task automatic model_reset();
      mq.delete();
      m_lfsr = 16'hACE1;
      m_viol = 2'b00;
      m_pend = 1'b0;
      m_prev = '0;
   endtask

   // One clock cycle: drive, compare against the model, advance model, cross the edge.
   task automatic step(input bit sv, input logic [63:0] pl, input bit mr,
                       input logic [1:0] md, input bit clr);
      bit e_rdy, push, pop;
      logic [1:0] nv;
      s_valid = sv; s_payload = pl; m_ready = mr; throttle_mode = md; clear_violation = clr;
      #1;
      e_rdy = (mq.size() != DEPTH) && gate_of(md, m_lfsr);
      chk("s_ready", s_ready, e_rdy);
      chk("m_valid", m_valid, mq.size() != 0);
      chk("count", count, mq.size());
      chk("violation", violation, m_viol);
      if (mq.size() != 0) chk("m_payload", m_payload, mq[0]);
      push = sv && e_rdy;
      pop  = (mq.size() != 0) && mr;
      nv   = {m_pend && sv && (pl != m_prev), m_pend && !sv};
      m_viol = (clr ? 2'b00 : m_viol) | nv;
      m_pend = sv && !e_rdy;
      m_prev = pl;
      m_lfsr = {^(m_lfsr & 16'h002D), m_lfsr[15:1]};
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(pl);
      @(posedge clock);
      #1;
   endtask

   initial begin
      tbl[0] = '{1'b1, 64'h11, 1'b0, 3'd0, 1'b0, 64'h0,  1'b1};
      tbl[1] = '{1'b1, 64'h22, 1'b0, 3'd1, 1'b1, 64'h11, 1'b1};
      tbl[2] = '{1'b1, 64'h33, 1'b0, 3'd2, 1'b1, 64'h11, 1'b1};
      tbl[3] = '{1'b1, 64'h44, 1'b0, 3'd3, 1'b1, 64'h11, 1'b1};
      tbl[4] = '{1'b0, 64'h0,  1'b0, 3'd4, 1'b1, 64'h11, 1'b0};
      tbl[5] = '{1'b0, 64'h0,  1'b1, 3'd4, 1'b1, 64'h11, 1'b0};
      tbl[6] = '{1'b0, 64'h0,  1'b1, 3'd3, 1'b1, 64'h22, 1'b1};
      tbl[7] = '{1'b0, 64'h0,  1'b1, 3'd2, 1'b1, 64'h33, 1'b1};
      tbl[8] = '{1'b0, 64'h0,  1'b1, 3'd1, 1'b1, 64'h44, 1'b1};
      tbl[9] = '{1'b0, 64'h0,  1'b0, 3'd0, 1'b0, 64'h0,  1'b1};

      reset_n = 1'b0; s_valid = 1'b1; s_payload = '0; m_ready = 1'b0;
      throttle_mode = 2'b00; clear_violation = 1'b0;
      #12;
      chk("rst_count", count, 3'd0);
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_s_ready", s_ready, 1'b0);
      chk("rst_violation", violation, 2'b00);
      @(posedge clock); #1;
      reset_n = 1'b1;
      model_reset();

      // Fill to full with downstream stalled, then drain in order.
      for (int i = 0; i < 10; i++) begin
         s_valid = tbl[i].sv; s_payload = tbl[i].pl; m_ready = tbl[i].mr;
         throttle_mode = 2'b00; clear_violation = 1'b0;
         #1;
         chk("tbl_count", count, tbl[i].e_cnt);
         chk("tbl_m_valid", m_valid, tbl[i].e_mv);
         chk("tbl_s_ready", s_ready, tbl[i].e_sr);
         if (tbl[i].e_mv) chk("tbl_m_payload", m_payload, tbl[i].e_mp);
         step(tbl[i].sv, tbl[i].pl, tbl[i].mr, 2'b00, 1'b0);
      end

      // First-word latency into an empty FIFO.
      step(1'b1, 64'hAB, 1'b0, 2'b00, 1'b0);
      chk("fwl_m_valid", m_valid, 1'b1);
      chk("fwl_m_payload", m_payload, 64'hAB);
      step(1'b0, 64'h0, 1'b1, 2'b00, 1'b0);

      // Steady push+pop at count 2 across pointer wrap.
      step(1'b1, 64'hA0, 1'b0, 2'b00, 1'b0);
      step(1'b1, 64'hA1, 1'b0, 2'b00, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 64'hB0 + 64'(i), 1'b1, 2'b00, 1'b0);
      chk("steady_count", count, 3'd2);
      chk("steady_head", m_payload, 64'hB8);
      step(1'b0, 64'h0, 1'b1, 2'b00, 1'b0);
      step(1'b0, 64'h0, 1'b1, 2'b00, 1'b0);

      // Stall mode, then LFSR 50% throttling.
      for (int i = 0; i < 8; i++) step(1'b1, 64'h55, 1'b0, 2'b10, 1'b0);
      chk("stall_count", count, 3'd0);
      for (int i = 0; i < 24; i++) step(1'b1, 64'h55, 1'b1, 2'b01, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 64'h0, 1'b1, 2'b00, 1'b1);

      // Hold-rule violations and clear priority.
      step(1'b1, 64'h5, 1'b0, 2'b10, 1'b0);
      step(1'b0, 64'h0, 1'b0, 2'b10, 1'b0);
      chk("viol_drop", violation, 2'b01);
      step(1'b0, 64'h0, 1'b0, 2'b00, 1'b1);
      chk("viol_clear1", violation, 2'b00);
      step(1'b1, 64'h6, 1'b0, 2'b10, 1'b0);
      step(1'b1, 64'h7, 1'b0, 2'b10, 1'b0);
      chk("viol_unstable", violation, 2'b10);
      step(1'b0, 64'h0, 1'b0, 2'b10, 1'b1);
      chk("viol_detect_wins", violation, 2'b01);
      step(1'b0, 64'h0, 1'b0, 2'b00, 1'b1);
      chk("viol_clear2", violation, 2'b00);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         logic [63:0] pl;
         pl = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 3));
         step($urandom_range(0, 3) != 0, pl, 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0);
      end

      // Asynchronous reset mid-cycle with three entries held.
      for (int i = 0; i < 6; i++) step(1'b0, 64'h0, 1'b1, 2'b00, 1'b1);
      step(1'b1, 64'hC1, 1'b0, 2'b00, 1'b0);
      step(1'b1, 64'hC2, 1'b0, 2'b00, 1'b0);
      step(1'b1, 64'hC3, 1'b0, 2'b00, 1'b0);
      chk("pre_rst_count", count, 3'd3);
      s_valid = 1'b0; m_ready = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_count", count, 3'd0);
      chk("async_m_valid", m_valid, 1'b0);
      chk("async_s_ready", s_ready, 1'b0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) step(1'b0, 64'h0, 1'b1, 2'b00, 1'b0);
      step(1'b1, 64'hD1, 1'b0, 2'b00, 1'b0);
      chk("post_rst_m_valid", m_valid, 1'b1);
      chk("post_rst_m_payload", m_payload, 64'hD1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pzvip_tilelink_channel_fifo.md
PZVIP_TILELINK_CHANNEL_FIFO -- requirements
Module: pzvip_tilelink_channel_fifo

Interface
REQ-001 Parameter WIDTH, default 64: payload width in bits, 1..1024.
REQ-002 Parameter DEPTH, default 4: entry count, power of two, 2..64.
REQ-003 Parameter LFSR_SEED, default 16'hACE1: nonzero LFSR reset value.
REQ-004 Port clock  in  1: single clock; all state updates on rising edge.
REQ-005 Port reset_n  in  1: reset is asynchronous and active-low.
REQ-006 Port s_valid  in  1: upstream valid.
REQ-007 Port s_ready  out  1: upstream ready.
REQ-008 Port s_payload  in  WIDTH: upstream payload.
REQ-009 Port m_valid  out  1: downstream valid.
REQ-010 Port m_ready  in  1: downstream ready.
REQ-011 Port m_payload  out  WIDTH: downstream payload.
REQ-012 Port throttle_mode  in  2: 00 none, 01 LFSR 50%, 10 stall, 11 LFSR 75%.
REQ-013 Port count  out  $clog2(DEPTH+1): current occupancy.
REQ-014 Port violation  out  2: sticky flags; [0] valid dropped, [1] payload unstable.
REQ-015 Port clear_violation  in  1: clears violation flags.

Function
REQ-016 Push SHALL occur when s_valid && s_ready; pop SHALL occur when m_valid && m_ready.
REQ-017 Storage SHALL be a circular buffer; read/write pointers SHALL wrap from DEPTH-1 to 0.
REQ-018 m_valid SHALL equal (count != 0); m_payload SHALL be the head entry, registered, no fall-through.
REQ-019 First-word latency SHALL be 1 cycle: push at edge N makes m_valid 1 after edge N.
REQ-020 s_ready SHALL equal (count != DEPTH) && gate, with no combinational path from m_ready.
REQ-021 gate SHALL be: mode 00 -> 1; 01 -> lfsr[0]; 10 -> 0; 11 -> (lfsr[1:0] != 0).
REQ-022 LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, advancing every cycle regardless of mode.
REQ-023 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and preserve order.
REQ-024 When full, s_ready SHALL be 0 even if m_ready is 1 in the same cycle.
REQ-025 When empty, pop SHALL be impossible; count SHALL never underflow or exceed DEPTH.
REQ-026 throttle_mode changes SHALL take effect on s_ready combinationally in the same cycle.
REQ-027 violation[0] SHALL set at edge N+1 if s_valid && !s_ready at edge N and s_valid == 0 at edge N+1.
REQ-028 violation[1] SHALL set at edge N+1 if s_valid && !s_ready at edge N and s_payload differs at edge N+1 while s_valid == 1.
REQ-029 clear_violation SHALL zero both flags on the next edge; a same-cycle new detection SHALL win over clear.
REQ-030 Stored contents of popped entries SHALL not be observable; m_payload is don't-care when m_valid == 0.

Reset
REQ-031 reset_n low SHALL immediately force count = 0, m_valid = 0, pointers = 0, violation = 0, lfsr = LFSR_SEED.
REQ-032 s_ready during reset SHALL be 0; after release it SHALL follow REQ-020.
REQ-033 Storage array contents SHALL not require reset.
REQ-034 Reset asserted mid-transfer SHALL discard all entries; no pop SHALL follow release until a new push.

Verification
REQ-035 DEPTH=4, mode 00, m_ready=0, push 0x11,0x22,0x33,0x44 -> count=4, s_ready=0; then m_ready=1 -> outputs 0x11..0x44 in order, one per cycle.
REQ-036 Empty FIFO, push 0xAB at edge N -> m_valid=1 and m_payload=0xAB after edge N, not before.
REQ-037 count=2, push and pop every cycle for 10 cycles -> count stays 2, order preserved across pointer wrap.
REQ-038 Mode 10, s_valid=1 -> s_ready=0 forever, count=0; mode 01 with LFSR_SEED=16'hACE1 -> s_ready matches the reference LFSR bit-0 sequence.
REQ-039 s_valid=1, s_ready=0 at edge N, s_valid=0 at N+1 -> violation=2'b01; payload change instead -> 2'b10; clear_violation -> 2'b00.
REQ-040 count=3, assert reset_n=0 asynchronously between edges -> count=0, m_valid=0 immediately; after release m_valid stays 0 until a push.
